// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, reset PC and the fetch queue entry type
package fetch_pkg;

   localparam int ADDRESS_WIDTH = 32;
   localparam int DATA_WIDTH    = 32;
   localparam logic [ADDRESS_WIDTH-1:0] RESET_PC = 32'hBFC0_0000;
   localparam int PC_STEP       = 4;

   typedef struct packed {
      logic [ADDRESS_WIDTH-1:0] pc;
      logic [DATA_WIDTH-1:0]    instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - ROM, redirect and decode-side signals of the fetch unit
interface fetch_if;
   import fetch_pkg::*;

   logic [ADDRESS_WIDTH-1:0] imem_addr;
   logic [DATA_WIDTH-1:0]    imem_instr;
   logic                     redirect_en;
   logic [ADDRESS_WIDTH-1:0] redirect_pc;
   logic                     out_valid;
   logic                     out_ready;
   logic [DATA_WIDTH-1:0]    out_instr;
   logic [ADDRESS_WIDTH-1:0] out_pc;

   modport master (
      output imem_addr,
      input  imem_instr,
      input  redirect_en,
      input  redirect_pc,
      output out_valid,
      input  out_ready,
      output out_instr,
      output out_pc
   );

   modport slave (
      input  imem_addr,
      output imem_instr,
      output redirect_en,
      output redirect_pc,
      input  out_valid,
      output out_ready,
      input  out_instr,
      input  out_pc
   );

endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order FIFO of {pc, instr} entries with single-cycle flush
module fetch_queue
   import fetch_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  fetch_entry_t din,
   output logic [CW-1:0] count,
   output fetch_entry_t head
);

   fetch_entry_t  mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: count gates every read of it.
   always_ff @(posedge clk) begin
      if (push && !flush && !rst) mem[wr_ptr] <= din;
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch PC, ROM addressing and redirect control feeding the fetch queue
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input logic      clk,
   input logic      rst,
   fetch_if.master  bus
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [ADDRESS_WIDTH-1:0] fetch_pc;
   logic [CW-1:0]            count;
   fetch_entry_t             head;
   fetch_entry_t             entry;
   logic                     valid;
   logic                     push;
   logic                     pop;

   assign valid = (count != '0);
   assign pop   = valid & bus.out_ready;
   // A pop frees a slot in the same cycle, so a full queue still streams.
   assign push  = !bus.redirect_en & ((count < CW'(DEPTH)) | pop);

   assign entry.pc    = fetch_pc;
   assign entry.instr = bus.imem_instr;

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
      end else if (bus.redirect_en) begin
         fetch_pc <= bus.redirect_pc & ~ADDRESS_WIDTH'(3);
      end else if (push) begin
         fetch_pc <= fetch_pc + ADDRESS_WIDTH'(PC_STEP);
      end
   end

   fetch_queue #(.DEPTH(DEPTH)) u_queue (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (bus.redirect_en),
      .din   (entry),
      .count (count),
      .head  (head)
   );

   assign bus.imem_addr = fetch_pc;
   assign bus.out_valid = valid;
   assign bus.out_pc    = valid ? head.pc    : '0;
   assign bus.out_instr = valid ? head.instr : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench with a queue-level reference model of fetch_unit
module tb_fetch_unit;
   import fetch_pkg::*;

   localparam int TB_DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] rom_xor;
   int          errors = 0;
   int          checks = 0;
   bit          model_live = 1'b0;

   fetch_if bus ();

   fetch_unit #(.DEPTH(TB_DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   assign bus.imem_instr = bus.imem_addr ^ rom_xor;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: a plain list of pending {pc, instr} pairs and a fetch cursor.
   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] m_pc;

   always @(posedge clk) begin
      if (rst) begin
         m_pc = RESET_PC;
         mq.delete();
         model_live = 1'b1;
      end else begin
         if (mq.size() > 0 && bus.out_ready) void'(mq.pop_front());
         if (bus.redirect_en) begin
            mq.delete();
            m_pc = {bus.redirect_pc[31:2], 2'b00};
         end else if (mq.size() < TB_DEPTH) begin
            mq.push_back('{pc: m_pc, instr: m_pc ^ rom_xor});
            m_pc = m_pc + 32'd4;
         end
      end
   end

   always @(negedge clk) begin
      if (model_live) begin
         check("m_imem_addr", bus.imem_addr, m_pc);
         check("m_out_valid", {31'd0, bus.out_valid}, {31'd0, mq.size() != 0});
         check("m_out_pc",    bus.out_pc,    (mq.size() != 0) ? mq[0].pc    : 32'd0);
         check("m_out_instr", bus.out_instr, (mq.size() != 0) ? mq[0].instr : 32'd0);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   logic [39:0] ready_pat;

   initial begin
      rst             = 1'b1;
      rom_xor         = 32'd0;
      bus.redirect_en = 1'b0;
      bus.redirect_pc = 32'd0;
      bus.out_ready   = 1'b0;
      cyc();
      cyc();
      check("rst_imem_addr", bus.imem_addr, 32'hBFC0_0000);
      check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_out_pc",    bus.out_pc,    32'd0);
      check("rst_out_instr", bus.out_instr, 32'd0);

      // streaming one per cycle after reset release
      rst           = 1'b0;
      bus.out_ready = 1'b1;
      cyc();
      check("t1_pc0",    bus.out_pc,    32'hBFC0_0000);
      check("t1_instr0", bus.out_instr, 32'hBFC0_0000);
      cyc();
      check("t1_pc1",    bus.out_pc,    32'hBFC0_0004);
      cyc();
      check("t1_pc2",    bus.out_pc,    32'hBFC0_0008);
      check("t1_instr2", bus.out_instr, 32'hBFC0_0008);

      // backpressure fills the queue and stalls the PC
      rst = 1'b1;
      cyc();
      rst           = 1'b0;
      bus.out_ready = 1'b0;
      repeat (5) cyc();
      check("t2_hold_addr",  bus.imem_addr, 32'hBFC0_0008);
      check("t2_hold_pc",    bus.out_pc,    32'hBFC0_0000);
      check("t2_hold_valid", {31'd0, bus.out_valid}, 32'd1);
      bus.out_ready = 1'b1;
      cyc();
      check("t2_pc1", bus.out_pc, 32'hBFC0_0004);
      cyc();
      check("t2_pc2", bus.out_pc, 32'hBFC0_0008);

      // redirect on a full queue with an accepted head
      bus.redirect_en = 1'b1;
      bus.redirect_pc = 32'hBFC0_0040;
      cyc();
      bus.redirect_en = 1'b0;
      check("t3_bubble", {31'd0, bus.out_valid}, 32'd0);
      check("t3_addr",   bus.imem_addr, 32'hBFC0_0040);
      cyc();
      check("t3_target", bus.out_pc, 32'hBFC0_0040);

      // low address bits ignored
      bus.redirect_en = 1'b1;
      bus.redirect_pc = 32'hBFC0_0043;
      cyc();
      bus.redirect_en = 1'b0;
      check("t4_align", bus.imem_addr, 32'hBFC0_0040);
      cyc();

      // back-to-back redirects: last wins
      bus.redirect_en = 1'b1;
      bus.redirect_pc = 32'hBFC0_0100;
      cyc();
      bus.redirect_pc = 32'hBFC0_0200;
      cyc();
      bus.redirect_en = 1'b0;
      check("b2b_bubble", {31'd0, bus.out_valid}, 32'd0);
      check("b2b_addr",   bus.imem_addr, 32'hBFC0_0200);
      cyc();
      check("b2b_target", bus.out_pc, 32'hBFC0_0200);
      cyc();

      // reset dominates a simultaneous redirect
      rst             = 1'b1;
      bus.redirect_en = 1'b1;
      bus.redirect_pc = 32'hBFC0_0080;
      cyc();
      check("t5_addr",  bus.imem_addr, 32'hBFC0_0000);
      check("t5_valid", {31'd0, bus.out_valid}, 32'd0);
      check("t5_pc",    bus.out_pc, 32'd0);
      rst             = 1'b0;
      bus.redirect_en = 1'b0;
      cyc();
      check("t5_restart", bus.out_pc, 32'hBFC0_0000);

      // PC wraps at the top of the address space
      rom_xor         = 32'h1234_5678;
      bus.redirect_en = 1'b1;
      bus.redirect_pc = 32'hFFFF_FFFC;
      cyc();
      bus.redirect_en = 1'b0;
      check("t6_bubble", {31'd0, bus.out_valid}, 32'd0);
      cyc();
      check("t6_pc_top",    bus.out_pc,    32'hFFFF_FFFC);
      check("t6_instr_top", bus.out_instr, 32'hEDCB_A984);
      cyc();
      check("t6_pc_wrap",    bus.out_pc,    32'h0000_0000);
      check("t6_instr_wrap", bus.out_instr, 32'h1234_5678);

      // mixed ready pattern with a mid-stream redirect, checked by the model
      ready_pat = 40'hB3_5C_E1_07_9A;
      for (int i = 0; i < 40; i++) begin
         bus.out_ready   = ready_pat[i];
         bus.redirect_en = (i == 17) || (i == 29);
         bus.redirect_pc = (i == 17) ? 32'hBFC0_0300 : 32'h0000_1006;
         cyc();
      end
      bus.redirect_en = 1'b0;
      bus.out_ready   = 1'b1;
      repeat (4) cyc();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
